// File: rtl/clock_divider_multi.sv
// Multi-channel divider: slow clk_out plus 1-cycle tick per channel, with RUN/HALT/STEP debug modes.
// All outputs registered; tick and the clk_out toggle appear on the same edge; no backpressure.
module clock_divider_multi #(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 27,
    parameter int DEF_DIV     = 75000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic              step_btn,
    input  logic [NUM_CH-1:0] div_we,
    input  logic [CNT_W-1:0]  div_wdata,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_out,
    output logic              running,
    output logic              step_busy
);

    typedef enum logic [1:0] {M_HALT = 2'b00, M_RUN = 2'b01, M_STEP = 2'b10} mode_e;
    typedef enum logic {S_IDLE = 1'b0, S_HIGH = 1'b1} state_e;

    localparam logic [CNT_W-1:0] DEF_D = CNT_W'(DEF_DIV);

    mode_e                  mode_n, mode_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_prev_q;
    logic                   step_req, enter_step, leave_step;
    logic                   running_q, busy_q, busy_d;

    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [CNT_W-1:0]  act_q [NUM_CH];
    logic [CNT_W-1:0]  act_d [NUM_CH];
    logic [CNT_W-1:0]  shd_q [NUM_CH];
    logic [CNT_W-1:0]  shd_d [NUM_CH];
    state_e            st_q  [NUM_CH];
    state_e            st_d  [NUM_CH];
    logic [NUM_CH-1:0] clk_q, clk_d, tick_q, tick_d, wrap;

    // A zero divisor behaves as one: wrap on every cycle.
    function automatic logic [CNT_W-1:0] last_cnt(input logic [CNT_W-1:0] d);
        return (d == '0) ? '0 : d - CNT_W'(1);
    endfunction

    always_comb begin
        mode_n     = (mode == 2'b11) ? M_HALT : mode_e'(mode);
        enter_step = (mode_n == M_STEP) && (mode_q != M_STEP);
        leave_step = (mode_n != M_STEP) && (mode_q == M_STEP);
        step_req   = sync_q[SYNC_STAGES-1] && !btn_prev_q && !busy_q;
    end

    always_comb begin
        busy_d = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i]  = cnt_q[i];
            act_d[i]  = act_q[i];
            shd_d[i]  = div_we[i] ? div_wdata : shd_q[i];
            st_d[i]   = st_q[i];
            clk_d[i]  = clk_q[i];
            tick_d[i] = 1'b0;
            wrap[i]   = (cnt_q[i] >= last_cnt(act_q[i]));

            // Mode transitions into/out of STEP beat any wrap or step request this cycle.
            if (enter_step || leave_step) begin
                cnt_d[i] = '0;
                clk_d[i] = 1'b0;
                st_d[i]  = S_IDLE;
            end else if (mode_n == M_RUN || (mode_n == M_STEP && st_q[i] == S_HIGH)) begin
                if (wrap[i]) begin
                    cnt_d[i]  = '0;
                    clk_d[i]  = (mode_n == M_RUN) ? !clk_q[i] : 1'b0;
                    tick_d[i] = 1'b1;
                    act_d[i]  = shd_d[i];
                    st_d[i]   = S_IDLE;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end else begin
                // HALT, or STEP with this channel idle: divisor writes take effect now.
                if (div_we[i]) begin
                    act_d[i] = div_wdata;
                    cnt_d[i] = '0;
                end
                if (mode_n == M_STEP && step_req) begin
                    cnt_d[i]  = '0;
                    clk_d[i]  = 1'b1;
                    tick_d[i] = 1'b1;
                    st_d[i]   = S_HIGH;
                end
            end
            busy_d = busy_d | (st_d[i] == S_HIGH);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q     <= M_HALT;
            sync_q     <= '0;
            btn_prev_q <= 1'b0;
            running_q  <= 1'b0;
            busy_q     <= 1'b0;
            clk_q      <= '0;
            tick_q     <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
                act_q[i] <= DEF_D;
                shd_q[i] <= DEF_D;
                st_q[i]  <= S_IDLE;
            end
        end else begin
            mode_q     <= mode_n;
            sync_q     <= {sync_q[SYNC_STAGES-2:0], step_btn};
            btn_prev_q <= sync_q[SYNC_STAGES-1];
            running_q  <= (mode_n == M_RUN);
            busy_q     <= busy_d;
            clk_q      <= clk_d;
            tick_q     <= tick_d;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
                act_q[i] <= act_d[i];
                shd_q[i] <= shd_d[i];
                st_q[i]  <= st_d[i];
            end
        end
    end

    assign tick      = tick_q;
    assign clk_out   = clk_q;
    assign running   = running_q;
    assign step_busy = busy_q;

endmodule
